tlb_update: RTL



---
 rtl/mmu_pkg.sv | 29 ++
 rtl/tlb_update.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types for the TLB write-side engine.
// Holds the TLB entry layout, the update opcode, the engine state
// encoding and the "automatic / all ways" way selector value.
package mmu_pkg;

    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic [7:0]  asid;
        logic [3:0]  perm;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OP_NOP       = 2'd0,
        OP_WRITE     = 2'd1,
        OP_INV_ENTRY = 2'd2,
        OP_INV_ALL   = 2'd3
    } tlb_upd_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_SWEEP = 2'd2
    } tlb_upd_state_t;

    localparam logic [7:0] AUTO_WAY = 8'hFF;

endpackage

// File: rtl/tlb_update.sv
// tlb_update: write-side engine driving the per-way TLB RAM write ports.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                NOP / WRITE / INV_ENTRY / INV_ALL
//   hold_entry            entry written by WRITE
//   hold_entry_no         target row
//   hold_way              target way, AUTO_WAY = round-robin / all ways
//   lock_map              rows 0..63 protected from INV_ALL
//   wr_en/wr_adr/wr_dat   registered RAM write port
//   done, err             one-cycle completion / error pulses
//   last_way              way used by the most recent WRITE
module tlb_update
    import mmu_pkg::*;
#(
    parameter int TLB_ASSOC   = 4,
    parameter int TLB_ENTRIES = 1024,
    parameter int LOG_ENTRIES = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  tlb_upd_op_t            cmd_op,
    input  tlb_entry_t             hold_entry,
    input  logic [15:0]            hold_entry_no,
    input  logic [7:0]             hold_way,
    input  logic [63:0]            lock_map,
    output logic [TLB_ASSOC-1:0]   wr_en,
    output logic [LOG_ENTRIES-1:0] wr_adr,
    output tlb_entry_t             wr_dat,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             last_way
);

    tlb_upd_state_t         state_q, state_d;
    logic [LOG_ENTRIES:0]   cnt_q, cnt_d, cnt_nxt;
    logic [63:0]            lock_q, lock_d;
    logic [7:0]             rr_q, rr_d, last_way_q, last_way_d, way;
    logic [TLB_ASSOC-1:0]   wr_en_q, wr_en_d;
    logic [LOG_ENTRIES-1:0] wr_adr_q, wr_adr_d;
    tlb_entry_t             wr_dat_q, wr_dat_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   auto, bad, nxt_locked;

    assign auto       = hold_way == AUTO_WAY;
    assign bad        = int'(hold_entry_no) >= TLB_ENTRIES || (!auto && int'(hold_way) >= TLB_ASSOC);
    assign way        = auto ? rr_q : hold_way;
    assign cnt_nxt    = cnt_q + 1'b1;
    // Only rows below 64 are covered by the lock map.
    assign nxt_locked = int'(cnt_nxt) < 64 && lock_q[cnt_nxt[5:0]];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        last_way_d = last_way_q;
        wr_en_d    = '0;
        wr_adr_d   = wr_adr_q;
        wr_dat_d   = wr_dat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                case (cmd_op)
                    OP_NOP: done_d = 1'b1;
                    OP_INV_ALL: begin
                        state_d  = S_SWEEP;
                        cnt_d    = '0;
                        lock_d   = lock_map;
                        wr_adr_d = '0;
                        wr_dat_d = '0;
                        wr_en_d  = lock_map[0] ? '0 : '1;
                    end
                    default: if (bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d  = S_WRITE;
                        wr_adr_d = hold_entry_no[LOG_ENTRIES-1:0];
                        if (cmd_op == OP_WRITE) begin
                            wr_en_d    = TLB_ASSOC'(1) << way;
                            wr_dat_d   = hold_entry;
                            last_way_d = way;
                            if (auto) rr_d = rr_q == 8'(TLB_ASSOC - 1) ? 8'd0 : rr_q + 8'd1;
                        end else begin
                            wr_en_d  = auto ? '1 : TLB_ASSOC'(1) << hold_way;
                            wr_dat_d = '0;
                        end
                    end
                endcase
            end
            S_WRITE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: if (cnt_q == (LOG_ENTRIES + 1)'(TLB_ENTRIES - 1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d    = cnt_nxt;
                wr_adr_d = cnt_nxt[LOG_ENTRIES-1:0];
                wr_en_d  = nxt_locked ? '0 : '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lock_q     <= '0;
            rr_q       <= '0;
            last_way_q <= '0;
            wr_en_q    <= '0;
            wr_adr_q   <= '0;
            wr_dat_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            rr_q       <= rr_d;
            last_way_q <= last_way_d;
            wr_en_q    <= wr_en_d;
            wr_adr_q   <= wr_adr_d;
            wr_dat_q   <= wr_dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = state_q == S_IDLE;
    assign wr_en     = wr_en_q;
    assign wr_adr    = wr_adr_q;
    assign wr_dat    = wr_dat_q;
    assign done      = done_q;
    assign err       = err_q;
    assign last_way  = last_way_q;

endmodule
